ttt_nxn_engine: RTL

TTT_NXN_ENGINE -- requirements
Module: ttt_nxn_engine

---
 rtl/ttt_pkg.sv | 13 +
 rtl/ttt_line_scan.sv | 54 +++++
 rtl/ttt_nxn_engine.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types and owner codes for the N x N tic-tac-toe engine.
package ttt_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_MOVE, CHECK, GAME_OVER} state_e;
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_e;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] PLAYER = 2'b01;
  localparam logic [1:0] COMP   = 2'b10;

  function automatic logic [1:0] owner_code(input logic who);
    return who ? COMP : PLAYER;
  endfunction
endpackage

// File: rtl/ttt_line_scan.sv
// Combinational run length through one cell along one direction, clipped at board edges.
module ttt_line_scan
  import ttt_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = $clog2(N*N),
  parameter int RW = $clog2(N+1)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [PW-1:0]    pos,
  input  dir_e             dir,
  input  logic [1:0]       code,
  output logic [RW-1:0]    run
);
  // Padded to a power of two so any PW-bit index is in range.
  logic [(1<<PW)-1:0] match;

  for (genvar j = 0; j < (1<<PW); j++) begin : g_match
    if (j < N*N) begin : g_cell
      assign match[j] = (board[2*j +: 2] == code);
    end else begin : g_pad
      assign match[j] = 1'b0;
    end
  end

  always_comb begin
    int r, c, dr, dc, rr, cc, cnt;
    logic go;
    r = int'(pos) / N;
    c = int'(pos) % N;
    unique case (dir)
      DIR_H:   begin dr = 0; dc = 1;  end
      DIR_V:   begin dr = 1; dc = 0;  end
      DIR_D:   begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    cnt = 1;
    go  = 1'b1;
    for (int i = 1; i < N; i++) begin
      rr = r + i*dr;
      cc = c + i*dc;
      if (go && rr >= 0 && rr < N && cc >= 0 && cc < N && match[PW'(rr*N + cc)]) cnt++;
      else go = 1'b0;
    end
    go = 1'b1;
    for (int i = 1; i < N; i++) begin
      rr = r - i*dr;
      cc = c - i*dc;
      if (go && rr >= 0 && rr < N && cc >= 0 && cc < N && match[PW'(rr*N + cc)]) cnt++;
      else go = 1'b0;
    end
    run = RW'(cnt);
  end
endmodule

// File: rtl/ttt_nxn_engine.sv
// N x N, K-in-a-row referee: accepts alternating moves, checks four directions per move.
module ttt_nxn_engine
  import ttt_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int PW = $clog2(N*N),
  localparam int MW = $clog2(N*N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          play,
  input  logic          mv_valid,
  input  logic          mv_who,
  input  logic [PW-1:0] mv_pos,
  output logic          mv_ready,
  output logic          mv_err,
  output logic          win,
  output logic          who1,
  output logic          no_space,
  output logic [MW-1:0] move_cnt
);
  localparam int RW = $clog2(N+1);
  localparam logic [PW:0]   CELLS_P = (PW+1)'(N*N);
  localparam logic [MW-1:0] CELLS_M = MW'(N*N);
  localparam logic [RW-1:0] K_R     = RW'(K);

  state_e             state, state_nxt;
  dir_e               dir;
  logic [2*N*N-1:0]   board, board_nxt;
  logic [PW-1:0]      last_pos;
  logic               turn, found;
  logic [RW-1:0]      run;
  logic [(1<<PW)-1:0] occ;
  logic [1:0]         mover_code;
  logic               legal, bad, clr, hit, full, move_ok;

  assign mover_code = owner_code(turn);
  assign mv_ready   = (state == WAIT_MOVE);
  assign hit        = found | (run >= K_R);
  assign full       = (move_cnt == CELLS_M);

  for (genvar j = 0; j < (1<<PW); j++) begin : g_occ
    if (j < N*N) begin : g_cell
      assign occ[j] = (board[2*j +: 2] != EMPTY);
      assign board_nxt[2*j +: 2] = (mv_pos == PW'(j)) ? mover_code : board[2*j +: 2];
    end else begin : g_pad
      assign occ[j] = 1'b0;
    end
  end

  assign move_ok = ({1'b0, mv_pos} < CELLS_P) && !occ[mv_pos] && (mv_who == turn);

  // One scanner, stepped through the four directions while in CHECK.
  ttt_line_scan #(.N(N), .PW(PW), .RW(RW)) u_scan (
    .board(board),
    .pos  (last_pos),
    .dir  (dir),
    .code (mover_code),
    .run  (run)
  );

  always_comb begin
    state_nxt = state;
    legal     = 1'b0;
    bad       = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: if (play) begin
        clr       = 1'b1;
        state_nxt = WAIT_MOVE;
      end
      WAIT_MOVE: if (mv_valid) begin
        if (move_ok) begin
          legal     = 1'b1;
          state_nxt = CHECK;
        end else begin
          bad = 1'b1;
        end
      end
      CHECK: if (dir == DIR_A) state_nxt = (hit || full) ? GAME_OVER : WAIT_MOVE;
      default: if (play) begin
        clr       = 1'b1;
        state_nxt = WAIT_MOVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      board    <= '0;
      move_cnt <= '0;
      last_pos <= '0;
      turn     <= 1'b0;
      found    <= 1'b0;
      dir      <= DIR_H;
      mv_err   <= 1'b0;
      win      <= 1'b0;
      who1     <= 1'b0;
      no_space <= 1'b0;
    end else begin
      state  <= state_nxt;
      mv_err <= bad;
      if (clr) begin
        board    <= '0;
        move_cnt <= '0;
        win      <= 1'b0;
        who1     <= 1'b0;
        no_space <= 1'b0;
        found    <= 1'b0;
        turn     <= 1'b0;
        dir      <= DIR_H;
      end
      if (legal) begin
        board    <= board_nxt;
        move_cnt <= move_cnt + MW'(1);
        last_pos <= mv_pos;
        found    <= 1'b0;
        dir      <= DIR_H;
      end
      // Win is judged before fullness so a line on the last cell is not a draw.
      if (state == CHECK) begin
        found <= hit;
        dir   <= dir_e'(dir + 2'd1);
        if (dir == DIR_A) begin
          if (hit) begin
            win  <= 1'b1;
            who1 <= turn;
          end else if (full) begin
            no_space <= 1'b1;
          end else begin
            turn <= ~turn;
          end
        end
      end
    end
  end
endmodule
